// File: rtl/shared_reg_server_pkg.sv
// Shared types for the two-client shared-register lock protocol; also used by
// the client-side thread state machines.
package shared_reg_server_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn1 = 2'd1,
    StOwn2 = 2'd2
  } state_e;

  typedef enum logic {
    Client1 = 1'b0,
    Client2 = 1'b1
  } client_e;

  localparam int unsigned DefaultResetVal = 0;

endpackage

// File: rtl/shared_reg_server.sv
// Owner side of the shared-register RMW lock: round-robin grant, atomic write-on-release,
// hold timeout and non-owner violation flagging.
module shared_reg_server
  import shared_reg_server_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       HOLD_MAX  = 15,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(DefaultResetVal)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acq1,
  input  logic              acq2,
  input  logic              wr_en1,
  input  logic              wr_en2,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [DATA_W-1:0] wr_data2,
  input  logic              rel1,
  input  logic              rel2,
  output logic [DATA_W-1:0] rd_data,
  output logic              gnt1,
  output logic              gnt2,
  output logic              done1,
  output logic              done2,
  output logic              tmo1,
  output logic              tmo2,
  output logic              err
);

  localparam int unsigned CntW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CntW-1:0] HoldMaxCnt = CntW'(HOLD_MAX);

  state_e            state_q, state_d;
  client_e           last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done1_q, done1_d, done2_q, done2_d;
  logic              tmo1_q, tmo1_d, tmo2_q, tmo2_d;
  logic              err_q, err_d;

  client_e           own_id;
  logic              own_wr, own_rel, other_acq, hand_off, commit, revoke;
  logic [DATA_W-1:0] own_data;

  always_comb begin
    own_id    = (state_q == StOwn2) ? Client2 : Client1;
    own_wr    = (own_id == Client2) ? wr_en2 : wr_en1;
    own_rel   = (own_id == Client2) ? rel2 : rel1;
    own_data  = (own_id == Client2) ? wr_data2 : wr_data1;
    other_acq = (own_id == Client2) ? acq1 : acq2;

    state_d  = state_q;
    last_d   = last_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    hand_off = 1'b0;
    commit   = 1'b0;
    revoke   = 1'b0;
    // Any wr_en/rel from a client that does not hold the lock; folded into one pulse.
    err_d    = ((wr_en1 | rel1) && (state_q != StOwn1)) ||
               ((wr_en2 | rel2) && (state_q != StOwn2));

    if (state_q == StIdle) begin
      cnt_d = '0;
      if (acq1 && acq2) begin
        state_d = (last_q == Client1) ? StOwn2 : StOwn1;
      end else if (acq1) begin
        state_d = StOwn1;
      end else if (acq2) begin
        state_d = StOwn2;
      end
    end else begin
      if (own_wr) begin
        commit   = 1'b1;
        hand_off = 1'b1;
        data_d   = own_data;
      end else if (own_rel) begin
        hand_off = 1'b1;
      end else if ((HOLD_MAX != 0) && (cnt_q == HoldMaxCnt)) begin
        revoke   = 1'b1;
        hand_off = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end

      // Hand straight to a waiting peer so there is no idle cycle between owners.
      if (hand_off) begin
        last_d = own_id;
        cnt_d  = '0;
        if (other_acq) begin
          state_d = (own_id == Client1) ? StOwn2 : StOwn1;
        end else begin
          state_d = StIdle;
        end
      end
    end

    done1_d = commit && (own_id == Client1);
    done2_d = commit && (own_id == Client2);
    tmo1_d  = revoke && (own_id == Client1);
    tmo2_d  = revoke && (own_id == Client2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      last_q  <= Client2;
      data_q  <= RESET_VAL;
      cnt_q   <= '0;
      done1_q <= 1'b0;
      done2_q <= 1'b0;
      tmo1_q  <= 1'b0;
      tmo2_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done1_q <= done1_d;
      done2_q <= done2_d;
      tmo1_q  <= tmo1_d;
      tmo2_q  <= tmo2_d;
      err_q   <= err_d;
    end
  end

  assign rd_data = data_q;
  assign gnt1    = (state_q == StOwn1);
  assign gnt2    = (state_q == StOwn2);
  assign done1   = done1_q;
  assign done2   = done2_q;
  assign tmo1    = tmo1_q;
  assign tmo2    = tmo2_q;
  assign err     = err_q;

endmodule

// File: tb/tb_shared_reg_server.sv
// Two instances (HOLD_MAX=3 / RESET_VAL=0 and HOLD_MAX=0 / RESET_VAL=0x5A) share stimulus
// and are compared every cycle against a transaction-level model of the lock protocol.
module tb_shared_reg_server;

  logic       clk;
  logic       rst;
  logic       acq1, acq2, wr_en1, wr_en2, rel1, rel2;
  logic [7:0] wr_data1, wr_data2;

  logic [7:0] rd_a, rd_b;
  logic       gnt1_a, gnt2_a, done1_a, done2_a, tmo1_a, tmo2_a, err_a;
  logic       gnt1_b, gnt2_b, done1_b, done2_b, tmo1_b, tmo2_b, err_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance: owner 0 = nobody, else client number.
  int         m_own   [2];
  int         m_last  [2];
  int         m_cnt   [2];
  logic [7:0] m_reg   [2];
  bit         m_done  [2][3];
  bit         m_tmo   [2][3];
  bit         m_err   [2];

  localparam int         HoldMax  [2] = '{3, 0};
  localparam logic [7:0] ResetVal [2] = '{8'h00, 8'h5A};

  shared_reg_server #(
    .DATA_W   (8),
    .HOLD_MAX (3),
    .RESET_VAL(8'h00)
  ) u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .acq1    (acq1),
    .acq2    (acq2),
    .wr_en1  (wr_en1),
    .wr_en2  (wr_en2),
    .wr_data1(wr_data1),
    .wr_data2(wr_data2),
    .rel1    (rel1),
    .rel2    (rel2),
    .rd_data (rd_a),
    .gnt1    (gnt1_a),
    .gnt2    (gnt2_a),
    .done1   (done1_a),
    .done2   (done2_a),
    .tmo1    (tmo1_a),
    .tmo2    (tmo2_a),
    .err     (err_a)
  );

  shared_reg_server #(
    .DATA_W   (8),
    .HOLD_MAX (0),
    .RESET_VAL(8'h5A)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .acq1    (acq1),
    .acq2    (acq2),
    .wr_en1  (wr_en1),
    .wr_en2  (wr_en2),
    .wr_data1(wr_data1),
    .wr_data2(wr_data2),
    .rel1    (rel1),
    .rel2    (rel2),
    .rd_data (rd_b),
    .gnt1    (gnt1_b),
    .gnt2    (gnt2_b),
    .done1   (done1_b),
    .done2   (done2_b),
    .tmo1    (tmo1_b),
    .tmo2    (tmo2_b),
    .err     (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = 0;
      m_last[k] = 2;
      m_cnt[k]  = 0;
      m_reg[k]  = ResetVal[k];
      m_err[k]  = 1'b0;
      for (int c = 0; c < 3; c++) begin
        m_done[k][c] = 1'b0;
        m_tmo[k][c]  = 1'b0;
      end
    end
  endtask

  // One clock edge of the protocol, from the rules: grant, commit/release/timeout, handover.
  task automatic model_step();
    bit   acq [3];
    bit   wen [3];
    bit   rl  [3];
    logic [7:0] wd [3];
    acq[1] = acq1;   acq[2] = acq2;
    wen[1] = wr_en1; wen[2] = wr_en2;
    rl[1]  = rel1;   rl[2]  = rel2;
    wd[1]  = wr_data1; wd[2] = wr_data2;
    for (int k = 0; k < 2; k++) begin
      int  o;
      bit  leave;
      o = m_own[k];
      for (int c = 0; c < 3; c++) begin
        m_done[k][c] = 1'b0;
        m_tmo[k][c]  = 1'b0;
      end
      m_err[k] = 1'b0;
      for (int c = 1; c <= 2; c++) begin
        if ((wen[c] || rl[c]) && o != c) m_err[k] = 1'b1;
      end
      if (o == 0) begin
        m_cnt[k] = 0;
        if (acq[1] && acq[2]) m_own[k] = (m_last[k] == 1) ? 2 : 1;
        else if (acq[1]) m_own[k] = 1;
        else if (acq[2]) m_own[k] = 2;
      end else begin
        leave = 1'b1;
        if (wen[o]) begin
          m_reg[k]     = wd[o];
          m_done[k][o] = 1'b1;
        end else if (rl[o]) begin
          leave = 1'b1;
        end else if (HoldMax[k] != 0 && m_cnt[k] == HoldMax[k]) begin
          m_tmo[k][o] = 1'b1;
        end else begin
          leave = 1'b0;
          m_cnt[k]++;
        end
        if (leave) begin
          m_last[k] = o;
          m_cnt[k]  = 0;
          m_own[k]  = acq[3 - o] ? 3 - o : 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("A.ctrl", {25'd0, gnt1_a, gnt2_a, done1_a, done2_a, tmo1_a, tmo2_a, err_a},
             {25'd0, m_own[0] == 1, m_own[0] == 2, m_done[0][1], m_done[0][2],
              m_tmo[0][1], m_tmo[0][2], m_err[0]});
    check_eq("A.rd_data", {24'd0, rd_a}, {24'd0, m_reg[0]});
    check_eq("B.ctrl", {25'd0, gnt1_b, gnt2_b, done1_b, done2_b, tmo1_b, tmo2_b, err_b},
             {25'd0, m_own[1] == 1, m_own[1] == 2, m_done[1][1], m_done[1][2],
              m_tmo[1][1], m_tmo[1][2], m_err[1]});
    check_eq("B.rd_data", {24'd0, rd_b}, {24'd0, m_reg[1]});
  endtask

  // Called #1 after a rising edge; drives inputs, steps the model, checks after the next edge.
  task automatic cycle(input bit a1, input bit a2, input bit w1, input bit w2,
                       input bit r1, input bit r2, input logic [7:0] d1, input logic [7:0] d2);
    acq1 = a1; acq2 = a2; wr_en1 = w1; wr_en2 = w2; rel1 = r1; rel2 = r2;
    wr_data1 = d1; wr_data2 = d2;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Asserts reset between edges and checks the outputs drop without a clock edge.
  task automatic async_reset();
    acq1 = 0; acq2 = 0; wr_en1 = 0; wr_en2 = 0; rel1 = 0; rel2 = 0;
    #3 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  initial begin
    acq1 = 0; acq2 = 0; wr_en1 = 0; wr_en2 = 0; rel1 = 0; rel2 = 0;
    wr_data1 = '0; wr_data2 = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1 rst = 1'b1;
    compare_all();

    // Basic grant and write.
    cycle(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 1, 0, 0, 0, 8'h2A, 8'h00);
    cycle(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);

    // Simultaneous requests from reset; handover with no idle gap.
    async_reset();
    cycle(1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    cycle(1, 1, 1, 0, 0, 0, 8'h11, 8'h00);
    cycle(1, 1, 0, 0, 0, 1, 8'h00, 8'h00);
    cycle(0, 0, 0, 1, 0, 0, 8'h00, 8'hFF);
    cycle(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 1, 1, 1, 1, 8'h33, 8'h44);

    // Timeout on A (HOLD_MAX=3) with client 2 waiting; B keeps holding.
    for (int i = 0; i < 6; i++) cycle(i == 0, i > 0, 0, 0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 0, 1, 0, 1, 8'h00, 8'h10);
    cycle(0, 0, 0, 0, 1, 1, 8'h00, 8'h00);

    // Client 2 writes 0x10, regains the lock, then reset lands mid-ownership.
    cycle(0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 0, 1, 0, 0, 8'h00, 8'h10);
    cycle(0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    async_reset();
    cycle(1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);

    // Long hold: A revokes repeatedly as client 1 re-requests, B never times out.
    for (int i = 0; i < 100; i++) cycle(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    cycle(1, 0, 1, 0, 1, 0, 8'h55, 8'h00);
    cycle(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);

    // Randomized traffic with occasional asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              8'($urandom), 8'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shared_reg_server.md
Name: shared_reg_server

Overview:
- Responder/owner side of the two-client shared-register read-modify-write protocol.
- Holds the single shared data register.
- Grants exclusive access to one client at a time, with round-robin fairness between the two clients.
- Commits a write atomically as it releases the lock, and revokes locks held too long.
- Flags protocol violations by non-owners in hardware, so the two client state machines never write the register concurrently.

Parameters:
- DATA_W, 8, width of the shared register and the data ports.
- HOLD_MAX, 15, maximum number of owned cycles before forced revoke; 0 disables the timeout.
- RESET_VAL, 0, reset value of the shared register.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- acq1  input  1  client 1 requests the lock (level; held until gnt1 or abandoned).
- acq2  input  1  client 2 requests the lock.
- wr_en1  input  1  client 1 writes wr_data1 and releases the lock.
- wr_en2  input  1  client 2 writes wr_data2 and releases the lock.
- wr_data1  input  DATA_W  client 1 write data.
- wr_data2  input  DATA_W  client 2 write data.
- rel1  input  1  client 1 releases without writing.
- rel2  input  1  client 2 releases without writing.
- rd_data  output  DATA_W  current shared register value (direct register output).
- gnt1  output  1  client 1 owns the lock (registered level).
- gnt2  output  1  client 2 owns the lock (registered level).
- done1  output  1  one-cycle pulse: client 1 write committed.
- done2  output  1  one-cycle pulse: client 2 write committed.
- tmo1  output  1  one-cycle pulse: client 1 lock revoked by timeout.
- tmo2  output  1  one-cycle pulse: client 2 lock revoked by timeout.
- err  output  1  one-cycle pulse: wr_en/rel from a non-owner was ignored.

Behaviour:
- Reset (rst=0, async):
  - State=IDLE; shared register=RESET_VAL; hold_cnt=0; last_owner=2, so client 1 wins first.
  - All gnt/done/tmo/err outputs 0.
- States: IDLE, OWN1, OWN2. gnt1 = (state==OWN1); gnt2 = (state==OWN2). Never both high.
- IDLE:
  - One acq high → OWNx next cycle. Grant latency is one cycle from acq sampled.
  - Both acq high → grant the client that is not last_owner.
- OWNx, per cycle, in priority order:
  - wr_en_x=1: register ← wr_data_x at this edge; done_x pulses next cycle; go to handover.
  - Else rel_x=1: register unchanged; go to handover.
  - Else HOLD_MAX≠0 and hold_cnt==HOLD_MAX: revoke; tmo_x pulses next cycle; no write; go to handover.
  - Else hold_cnt increments.
- wr_en_x and rel_x high together: treated as a write.
- Handover:
  - last_owner ← x.
  - If the other client's acq is high → OWN_other; else → IDLE.
  - No dead cycle between owners.
  - A releasing client re-requesting immediately is served from IDLE next time, after the other client if it is waiting.
- hold_cnt: cleared on every grant; counts owned cycles; width clog2(HOLD_MAX+1), minimum 1 bit.
- Non-owner wr_en or rel:
  - Ignored; the register is never modified.
  - err pulses next cycle; multiple violations in one cycle give a single pulse.
- rd_data:
  - Always reflects the register.
  - A write becomes visible the cycle after wr_en, the same cycle done pulses.
- Reset mid-ownership: lock dropped immediately; the register returns to RESET_VAL; no done/tmo pulse.
- acq deasserted while waiting: no grant is issued. acq held by the owner is ignored.

Decomposition:
- Shared package: state enum (IDLE/OWN1/OWN2), client-id encoding, RESET_VAL default.
- The same package is used by the client thread state machines.
- No sub-module; arbitration, timer and register fit in one module.

Test Plan:
- Reset, then acq1 pulse held → gnt1=1 one cycle later; wr_en1 with wr_data1=0x2A → rd_data=0x2A and done1=1 next cycle, gnt1=0.
- acq1 and acq2 asserted together from reset → gnt1 first; wr_en1 → gnt2 next cycle with no IDLE gap; after rel2, simultaneous acq again → gnt1.
- gnt1 held, wr_en2 with 0xFF → err=1 one cycle, rd_data unchanged, gnt1 still 1.
- HOLD_MAX=3, client 1 owns and idles → tmo1 pulse after 4 owned cycles, gnt1=0, rd_data unchanged; with acq2 pending, gnt2=1 the same cycle gnt1 drops.
- Write 0x10 then rst=0 mid-OWN2 → gnt2=0 and rd_data=0x00 asynchronously; after release, acq1 and acq2 together → client 1 granted.
- HOLD_MAX=0, owner holds 100 cycles → no tmo; wr_en1 and rel1 together with 0x55 → commit, done1=1.
